// File: rtl/lcd_phy_if.sv
// lcd_phy_if: configuration-side handshake between the cfg register block
// (master) and the LCD PHY (slave).
//   phy_enable        - PHY enable
//   prescaler_10ns    - clk cycles per timing tick (0 behaves as 1)
//   busy_loop_cnt_max - busy polls allowed before a timeout error
//   lcd_instr         - {RS, RW, DB[7:0]}
//   valid_instr       - instruction pending
//   phy_read          - one-cycle accept pulse from the PHY
//   lcd_rdata         - last data read from the LCD
//   busy_error        - sticky busy-timeout flag
//   phy_busy          - PHY is not idle
interface lcd_phy_if #(
    parameter int DATA_WIDTH             = 8,
    parameter int INSTR_WIDTH            = 10,
    parameter int PRESCALER_WIDTH        = 16,
    parameter int CHECK_BUSY_ERROR_WIDTH = 16
);
    logic                              phy_enable;
    logic [PRESCALER_WIDTH-1:0]        prescaler_10ns;
    logic [CHECK_BUSY_ERROR_WIDTH-1:0] busy_loop_cnt_max;
    logic [INSTR_WIDTH-1:0]            lcd_instr;
    logic                              valid_instr;
    logic                              phy_read;
    logic [DATA_WIDTH-1:0]             lcd_rdata;
    logic                              busy_error;
    logic                              phy_busy;

    modport master (
        output phy_enable, prescaler_10ns, busy_loop_cnt_max, lcd_instr, valid_instr,
        input  phy_read, lcd_rdata, busy_error, phy_busy
    );

    modport slave (
        input  phy_enable, prescaler_10ns, busy_loop_cnt_max, lcd_instr, valid_instr,
        output phy_read, lcd_rdata, busy_error, phy_busy
    );
endinterface

// File: rtl/lcd_phy.sv
// lcd_phy: consumes instructions from the cfg block and drives an HD44780
// parallel bus with prescaled timing, then polls the busy flag.
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   cfg             - cfg-side handshake (lcd_phy_if slave modport)
//   lcd_rs_o        - register select
//   lcd_rw_o        - 1 = read
//   lcd_e_o         - enable strobe
//   lcd_db_o        - bus drive data
//   lcd_db_oe_o     - bus drive enable
//   lcd_db_i        - bus sampled data
module lcd_phy #(
    parameter int DATA_WIDTH             = 8,
    parameter int INSTR_WIDTH            = 10,
    parameter int PRESCALER_WIDTH        = 16,
    parameter int CHECK_BUSY_ERROR_WIDTH = 16,
    parameter int PHASE_WIDTH            = 8,
    parameter int T_AS_TICKS             = 6,
    parameter int T_PW_TICKS             = 45,
    parameter int T_LOW_TICKS            = 55
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    lcd_phy_if.slave              cfg,
    output logic                  lcd_rs_o,
    output logic                  lcd_rw_o,
    output logic                  lcd_e_o,
    output logic [DATA_WIDTH-1:0] lcd_db_o,
    output logic                  lcd_db_oe_o,
    input  logic [DATA_WIDTH-1:0] lcd_db_i
);
    localparam int CBW = CHECK_BUSY_ERROR_WIDTH;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SETUP      = 3'd1;
    localparam logic [2:0] S_EHIGH      = 3'd2;
    localparam logic [2:0] S_LOW        = 3'd3;
    localparam logic [2:0] S_POLL_SETUP = 3'd4;
    localparam logic [2:0] S_POLL_EHIGH = 3'd5;
    localparam logic [2:0] S_POLL_LOW   = 3'd6;

    logic [2:0]                 state_q, state_d;
    logic [PRESCALER_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic [PRESCALER_WIDTH-1:0] presc_q, presc_d;
    logic [PHASE_WIDTH-1:0]     phase_cnt_q, phase_cnt_d;
    logic [INSTR_WIDTH-1:0]     instr_q, instr_d;
    logic [CBW-1:0]             poll_cnt_q, poll_cnt_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       busy_err_q, busy_err_d;
    logic                       bf_q, bf_d;

    logic                       accept;
    logic                       tick;
    logic                       phase_done;
    logic [PHASE_WIDTH-1:0]     phase_last;
    logic [PRESCALER_WIDTH-1:0] presc_eff;
    logic [CBW:0]               poll_inc;
    logic                       instr_rs, instr_rw, busy_read;

    assign instr_rs  = instr_q[INSTR_WIDTH-1];
    assign instr_rw  = instr_q[INSTR_WIDTH-2];
    // A plain busy-flag read already reports BF; polling after it is pointless.
    assign busy_read = !instr_rs && instr_rw;

    assign presc_eff = (cfg.prescaler_10ns == '0) ? PRESCALER_WIDTH'(1) : cfg.prescaler_10ns;
    assign tick      = (tick_cnt_q == presc_q - PRESCALER_WIDTH'(1));
    assign poll_inc  = {1'b0, poll_cnt_q} + (CBW+1)'(1);

    always_comb begin
        case (state_q)
            S_SETUP, S_POLL_SETUP: phase_last = PHASE_WIDTH'(T_AS_TICKS - 1);
            S_EHIGH, S_POLL_EHIGH: phase_last = PHASE_WIDTH'(T_PW_TICKS - 1);
            S_LOW, S_POLL_LOW:     phase_last = PHASE_WIDTH'(T_LOW_TICKS - 1);
            default:               phase_last = '0;
        endcase
    end

    assign phase_done = (state_q != S_IDLE) && tick && (phase_cnt_q == phase_last);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        presc_d     = presc_q;
        phase_cnt_d = phase_cnt_q;
        instr_d     = instr_q;
        poll_cnt_d  = poll_cnt_q;
        rdata_d     = rdata_q;
        busy_err_d  = busy_err_q;
        bf_d        = bf_q;
        accept      = 1'b0;

        if (!cfg.phy_enable) busy_err_d = 1'b0;

        if (state_q == S_IDLE) begin
            if (cfg.phy_enable && cfg.valid_instr) begin
                accept     = 1'b1;
                instr_d    = cfg.lcd_instr;
                poll_cnt_d = '0;
                busy_err_d = 1'b0;
                state_d    = S_SETUP;
            end
        end else if (!cfg.phy_enable) begin
            state_d = S_IDLE;
        end else if (phase_done) begin
            case (state_q)
                S_SETUP: state_d = S_EHIGH;
                S_EHIGH: begin
                    if (instr_rw) rdata_d = lcd_db_i;
                    state_d = S_LOW;
                end
                S_LOW:        state_d = busy_read ? S_IDLE : S_POLL_SETUP;
                S_POLL_SETUP: state_d = S_POLL_EHIGH;
                S_POLL_EHIGH: begin
                    bf_d    = lcd_db_i[DATA_WIDTH-1];
                    state_d = S_POLL_LOW;
                end
                S_POLL_LOW: begin
                    if (!bf_q) begin
                        state_d = S_IDLE;
                    end else if (poll_inc >= {1'b0, cfg.busy_loop_cnt_max}) begin
                        // max of 0 falls through here after one poll, same as 1
                        busy_err_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        poll_cnt_d = poll_inc[CBW-1:0];
                        state_d    = S_POLL_SETUP;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + PRESCALER_WIDTH'(1);
            if (tick) phase_cnt_d = phase_cnt_q + PHASE_WIDTH'(1);
        end

        // Every state entry restarts timing and picks up the current prescaler,
        // so a mid-transaction prescaler change only affects the next phase.
        if (state_d != state_q) begin
            tick_cnt_d  = '0;
            phase_cnt_d = '0;
            presc_d     = presc_eff;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            presc_q     <= '0;
            phase_cnt_q <= '0;
            instr_q     <= '0;
            poll_cnt_q  <= '0;
            rdata_q     <= '0;
            busy_err_q  <= 1'b0;
            bf_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            presc_q     <= presc_d;
            phase_cnt_q <= phase_cnt_d;
            instr_q     <= instr_d;
            poll_cnt_q  <= poll_cnt_d;
            rdata_q     <= rdata_d;
            busy_err_q  <= busy_err_d;
            bf_q        <= bf_d;
        end
    end

    // Bus pins are decoded from the registered state, so E and DB/OE only
    // ever change on state boundaries; OE is settled during SETUP before E rises.
    always_comb begin
        lcd_rs_o    = 1'b0;
        lcd_rw_o    = 1'b0;
        lcd_e_o     = 1'b0;
        lcd_db_o    = '0;
        lcd_db_oe_o = 1'b0;
        case (state_q)
            S_SETUP, S_EHIGH, S_LOW: begin
                lcd_rs_o    = instr_rs;
                lcd_rw_o    = instr_rw;
                lcd_db_oe_o = !instr_rw;
                lcd_db_o    = instr_q[DATA_WIDTH-1:0];
                lcd_e_o     = (state_q == S_EHIGH);
            end
            S_POLL_SETUP, S_POLL_EHIGH, S_POLL_LOW: begin
                lcd_rw_o = 1'b1;
                lcd_e_o  = (state_q == S_POLL_EHIGH);
            end
            default: ;
        endcase
    end

    // accept is combinational from inputs; gate it so reset forces it low too.
    assign cfg.phy_read   = accept && rst_ni;
    assign cfg.lcd_rdata  = rdata_q;
    assign cfg.busy_error = busy_err_q;
    assign cfg.phy_busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_lcd_phy.sv
// tb_lcd_phy: directed self-checking bench for lcd_phy.
module tb_lcd_phy;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_rs, lcd_rw, lcd_e, lcd_db_oe;
    logic [7:0] lcd_db_o;
    logic [7:0] lcd_db_i = 8'h00;

    int errors = 0;
    int checks = 0;

    // per-transaction observations
    int         first_e, w0, pulses, busy_cyc, rd_pulses;
    logic       oe_seen, acc_seen;
    logic [7:0] db_at_e, db_after;
    logic       rs_at_e, rw_at_e, oe_at_e;
    logic [7:0] rdata_save;

    lcd_phy_if #(.DATA_WIDTH(8), .INSTR_WIDTH(10), .PRESCALER_WIDTH(16),
                 .CHECK_BUSY_ERROR_WIDTH(16)) cfg_if ();

    lcd_phy u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cfg         (cfg_if),
        .lcd_rs_o    (lcd_rs),
        .lcd_rw_o    (lcd_rw),
        .lcd_e_o     (lcd_e),
        .lcd_db_o    (lcd_db_o),
        .lcd_db_oe_o (lcd_db_oe),
        .lcd_db_i    (lcd_db_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Issue one instruction and watch the bus until the PHY goes idle.
    // Cycle 0 is the first cycle in SETUP.
    task automatic run_txn(input logic [9:0] instr, input int budget);
        logic prev_e;
        int   k;
        first_e = -1; w0 = 0; pulses = 0; rd_pulses = 0; oe_seen = 0;
        db_at_e = 0; rs_at_e = 0; rw_at_e = 0; oe_at_e = 0;
        @(negedge clk);
        cfg_if.lcd_instr   = instr;
        cfg_if.valid_instr = 1'b1;
        #1 acc_seen = cfg_if.phy_read;
        @(posedge clk);
        #1 cfg_if.valid_instr = 1'b0;
        prev_e = 1'b0;
        k = 0;
        forever begin
            @(negedge clk);
            if (!cfg_if.phy_busy) break;
            if (k >= budget) begin
                chk("txn_timeout", 32'(k), 32'(budget + 1));
                break;
            end
            if (lcd_e && !prev_e) begin
                pulses++;
                if (pulses == 1) begin
                    first_e = k; db_at_e = lcd_db_o; rs_at_e = lcd_rs;
                    rw_at_e = lcd_rw; oe_at_e = lcd_db_oe;
                end
            end
            if (lcd_e && pulses == 1) w0++;
            if (!lcd_e && prev_e && pulses == 1) lcd_db_i = db_after;
            oe_seen   |= lcd_db_oe;
            rd_pulses += int'(cfg_if.phy_read);
            prev_e = lcd_e;
            k++;
        end
        busy_cyc = k;
    endtask

    initial begin
        cfg_if.phy_enable        = 1'b1;
        cfg_if.prescaler_10ns    = 16'd1;
        cfg_if.busy_loop_cnt_max = 16'd5;
        cfg_if.lcd_instr         = 10'h000;
        cfg_if.valid_instr       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {lcd_rs, lcd_rw, lcd_e, lcd_db_oe, lcd_db_o, cfg_if.phy_read,
                         cfg_if.busy_error, cfg_if.phy_busy, cfg_if.lcd_rdata}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", {31'h0, cfg_if.phy_busy}, 32'h0);

        // write 0x038, prescaler 1, not busy
        lcd_db_i = 8'h00; db_after = 8'h00;
        run_txn(10'h038, 2000);
        chk("wr_accept", {31'h0, acc_seen}, 32'h1);
        chk("wr_rd_pulses", 32'(rd_pulses), 32'h0);
        chk("wr_first_e", 32'(first_e), 32'd6);
        chk("wr_e_width", 32'(w0), 32'd45);
        chk("wr_bus", {20'h0, db_at_e, rs_at_e, rw_at_e, oe_at_e, 1'b0}, {20'h0, 8'h38, 4'b0010});
        chk("wr_pulses", 32'(pulses), 32'd2);
        chk("wr_busy_cyc", 32'(busy_cyc), 32'd212);
        chk("wr_no_err", {31'h0, cfg_if.busy_error}, 32'h0);

        // read data 0x341: 0xA5 sampled at E fall, then BF released for the poll
        lcd_db_i = 8'hA5; db_after = 8'h00;
        run_txn(10'h341, 2000);
        chk("rd_rdata", {24'h0, cfg_if.lcd_rdata}, 32'hA5);
        chk("rd_oe_never", {31'h0, oe_seen}, 32'h0);
        chk("rd_rs_rw", {30'h0, rs_at_e, rw_at_e}, 32'h3);
        chk("rd_pulses", 32'(pulses), 32'd2);

        // busy-flag read 0x100: no poll afterwards
        lcd_db_i = 8'h05; db_after = 8'h05;
        run_txn(10'h100, 2000);
        chk("bfrd_pulses", 32'(pulses), 32'd1);
        chk("bfrd_busy_cyc", 32'(busy_cyc), 32'd106);
        chk("bfrd_rdata", {24'h0, cfg_if.lcd_rdata}, 32'h05);

        // busy timeout: BF stuck, max 3
        cfg_if.busy_loop_cnt_max = 16'd3;
        lcd_db_i = 8'h80; db_after = 8'h80;
        run_txn(10'h001, 2000);
        chk("to_pulses", 32'(pulses), 32'd4);
        chk("to_err", {31'h0, cfg_if.busy_error}, 32'h1);
        chk("to_rdata_kept", {24'h0, cfg_if.lcd_rdata}, 32'h05);
        // next accept clears the error
        lcd_db_i = 8'h00; db_after = 8'h00;
        @(negedge clk);
        cfg_if.lcd_instr = 10'h002; cfg_if.valid_instr = 1'b1;
        @(posedge clk);
        #1 cfg_if.valid_instr = 1'b0;
        chk("to_err_clr", {31'h0, cfg_if.busy_error}, 32'h0);
        for (int i = 0; i < 400 && cfg_if.phy_busy; i++) @(negedge clk);
        chk("to_back_idle", {31'h0, cfg_if.phy_busy}, 32'h0);

        // busy max 0 behaves as 1
        cfg_if.busy_loop_cnt_max = 16'd0;
        lcd_db_i = 8'h80; db_after = 8'h80;
        run_txn(10'h001, 2000);
        chk("max0_pulses", 32'(pulses), 32'd2);
        chk("max0_err", {31'h0, cfg_if.busy_error}, 32'h1);

        // prescaler 4
        cfg_if.busy_loop_cnt_max = 16'd5;
        cfg_if.prescaler_10ns = 16'd4;
        lcd_db_i = 8'h00; db_after = 8'h00;
        run_txn(10'h006, 3000);
        chk("p4_first_e", 32'(first_e), 32'd24);
        chk("p4_e_width", 32'(w0), 32'd180);
        chk("p4_busy_cyc", 32'(busy_cyc), 32'd848);

        // prescaler 0 behaves as 1
        cfg_if.prescaler_10ns = 16'd0;
        run_txn(10'h00C, 2000);
        chk("p0_first_e", 32'(first_e), 32'd6);
        chk("p0_e_width", 32'(w0), 32'd45);
        chk("p0_busy_cyc", 32'(busy_cyc), 32'd212);

        // abort during POLL_EHIGH
        cfg_if.prescaler_10ns = 16'd1;
        cfg_if.busy_loop_cnt_max = 16'd10;
        lcd_db_i = 8'h80;
        rdata_save = cfg_if.lcd_rdata;
        @(negedge clk);
        cfg_if.lcd_instr = 10'h038; cfg_if.valid_instr = 1'b1;
        @(posedge clk);
        #1 cfg_if.valid_instr = 1'b0;
        begin
            int   np;
            logic pe;
            np = 0; pe = 1'b0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (lcd_e && !pe) np++;
                pe = lcd_e;
                if (np == 2 && lcd_e) break;
            end
            chk("ab_in_poll_e", {30'h0, lcd_e, lcd_rw}, 32'h3);
        end
        cfg_if.phy_enable = 1'b0;
        cfg_if.lcd_instr = 10'h080; cfg_if.valid_instr = 1'b1;
        @(negedge clk);
        chk("ab_bus_low", {28'h0, lcd_e, lcd_db_oe, lcd_rs, lcd_rw}, 32'h0);
        chk("ab_idle", {31'h0, cfg_if.phy_busy}, 32'h0);
        chk("ab_no_read", {31'h0, cfg_if.phy_read}, 32'h0);
        chk("ab_rdata_kept", {24'h0, cfg_if.lcd_rdata}, {24'h0, rdata_save});
        @(negedge clk);
        chk("ab_still_no_read", {30'h0, cfg_if.phy_read, cfg_if.phy_busy}, 32'h0);
        cfg_if.phy_enable = 1'b1;
        #1 chk("ab_read_on_en", {31'h0, cfg_if.phy_read}, 32'h1);
        cfg_if.valid_instr = 1'b0;
        lcd_db_i = 8'h00; db_after = 8'h00;

        // async reset mid-EHIGH
        @(negedge clk);
        cfg_if.lcd_instr = 10'h038; cfg_if.valid_instr = 1'b1;
        @(posedge clk);
        #1 cfg_if.valid_instr = 1'b0;
        repeat (10) @(negedge clk);
        chk("rs_in_ehigh", {31'h0, lcd_e}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("rs_async_outs", {lcd_rs, lcd_rw, lcd_e, lcd_db_oe, lcd_db_o, cfg_if.phy_read,
                                  cfg_if.busy_error, cfg_if.phy_busy, cfg_if.lcd_rdata}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_idle_after", {30'h0, cfg_if.phy_busy, lcd_e}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
